// File: rtl/pipe_in_check.sv
// Pipe-in data checker: verifies incoming words against a selectable pattern and models
// a throttled virtual FIFO for pipe_in_ready. Optional first-error capture: PIPE_IN_CHECK_ERRLOG_EN.
module pipe_in_check (
   input  logic        clk,
   input  logic        reset,
   input  logic        pipe_in_write,
   input  logic [31:0] pipe_in_data,
   output logic        pipe_in_ready,
   input  logic        throttle_set,
   input  logic [31:0] throttle_val,
   input  logic [31:0] fixed_pattern,
   input  logic [2:0]  pattern,
   output logic [31:0] word_count,
   output logic [31:0] error_count,
   output logic        error_flag
`ifdef PIPE_IN_CHECK_ERRLOG_EN
   ,
   output logic [31:0] first_err_index,
   output logic [31:0] first_err_expected,
   output logic [31:0] first_err_actual
`endif
);

   localparam logic [2:0]  MODE_FIXED  = 3'd0;
   localparam logic [2:0]  MODE_COUNT  = 3'd1;
   localparam logic [2:0]  MODE_LFSR   = 3'd2;
   localparam logic [2:0]  MODE_WALK1  = 3'd3;
   localparam logic [15:0] READY_LIMIT = 16'd64512;

   logic [31:0] exp_q, exp_d;
   logic [31:0] word_count_q, word_count_d;
   logic [31:0] error_count_q, error_count_d;
   logic        error_flag_q, error_flag_d;
   logic [15:0] level_q, level_d;
   logic        pipe_in_ready_q, pipe_in_ready_d;
   logic [31:0] throttle_q, throttle_d;
   logic [31:0] seed;
   logic [31:0] exp_cur;
   logic        mismatch;

   function automatic logic [31:0] lfsr_next(input logic [31:0] e);
      return {e[30:0], e[31] ^ e[21] ^ e[1] ^ e[0]};
   endfunction

   always_comb begin
      case (pattern)
         MODE_COUNT: seed = 32'h0000_0001;
         MODE_LFSR:  seed = 32'h0D0C_0B0A;
         MODE_WALK1: seed = 32'h0000_0001;
         default:    seed = 32'h0000_0000;
      endcase
   end

   // FIXED mode compares against the live input; reserved modes (pattern[2]=1) never flag.
   always_comb begin
      exp_cur  = (pattern == MODE_FIXED) ? fixed_pattern : exp_q;
      mismatch = pipe_in_write & ~pattern[2] & (pipe_in_data != exp_cur);
   end

   always_comb begin
      exp_d = exp_q;
      if (pipe_in_write) begin
         case (pattern)
            MODE_COUNT: exp_d = exp_q + 32'd1;
            MODE_LFSR:  exp_d = lfsr_next(exp_q);
            MODE_WALK1: exp_d = {exp_q[30:0], exp_q[31]};
            default:    exp_d = exp_q;
         endcase
      end

      word_count_d = word_count_q;
      if (pipe_in_write)
         word_count_d = word_count_q + 32'd1;

      error_count_d = error_count_q;
      if (mismatch && (error_count_q != 32'hFFFF_FFFF))
         error_count_d = error_count_q + 32'd1;

      error_flag_d = error_flag_q | mismatch;

      throttle_d = throttle_set ? throttle_val : {throttle_q[0], throttle_q[31:1]};

      // Writes fill and throttle bits drain the virtual FIFO; both at once cancel out.
      level_d = level_q;
      case ({pipe_in_write, throttle_q[0]})
         2'b10:   if (level_q != 16'hFFFF) level_d = level_q + 16'd1;
         2'b01:   if (level_q != 16'h0000) level_d = level_q - 16'd1;
         default: level_d = level_q;
      endcase

      pipe_in_ready_d = (level_q < READY_LIMIT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         exp_q           <= seed;
         word_count_q    <= 32'd0;
         error_count_q   <= 32'd0;
         error_flag_q    <= 1'b0;
         throttle_q      <= throttle_val;
         level_q         <= 16'd0;
         pipe_in_ready_q <= 1'b0;
      end else begin
         exp_q           <= exp_d;
         word_count_q    <= word_count_d;
         error_count_q   <= error_count_d;
         error_flag_q    <= error_flag_d;
         throttle_q      <= throttle_d;
         level_q         <= level_d;
         pipe_in_ready_q <= pipe_in_ready_d;
      end
   end

   assign pipe_in_ready = pipe_in_ready_q;
   assign word_count    = word_count_q;
   assign error_count   = error_count_q;
   assign error_flag    = error_flag_q;

`ifdef PIPE_IN_CHECK_ERRLOG_EN
   logic [31:0] first_err_index_q, first_err_index_d;
   logic [31:0] first_err_expected_q, first_err_expected_d;
   logic [31:0] first_err_actual_q, first_err_actual_d;

   // Capture only on the mismatch that sets the sticky flag.
   always_comb begin
      first_err_index_d    = first_err_index_q;
      first_err_expected_d = first_err_expected_q;
      first_err_actual_d   = first_err_actual_q;
      if (mismatch && !error_flag_q) begin
         first_err_index_d    = word_count_q;
         first_err_expected_d = exp_cur;
         first_err_actual_d   = pipe_in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         first_err_index_q    <= 32'd0;
         first_err_expected_q <= 32'd0;
         first_err_actual_q   <= 32'd0;
      end else begin
         first_err_index_q    <= first_err_index_d;
         first_err_expected_q <= first_err_expected_d;
         first_err_actual_q   <= first_err_actual_d;
      end
   end

   assign first_err_index    = first_err_index_q;
   assign first_err_expected = first_err_expected_q;
   assign first_err_actual   = first_err_actual_q;
`endif

endmodule

// File: tb/tb_pipe_in_check.sv
// Scoreboard bench for pipe_in_check: stimulus queues timed expectations, a negedge monitor
// compares them. Define PIPE_IN_CHECK_ERRLOG_EN to also check the first-error capture ports.
module tb_pipe_in_check;

   localparam int F_WC    = 0;
   localparam int F_EC    = 1;
   localparam int F_EF    = 2;
   localparam int F_RDY   = 3;
   localparam int F_IDX   = 4;
   localparam int F_EXP   = 5;
   localparam int F_ACT   = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_in_write;
   logic [31:0] pipe_in_data;
   logic        pipe_in_ready;
   logic        throttle_set;
   logic [31:0] throttle_val;
   logic [31:0] fixed_pattern;
   logic [2:0]  pattern;
   logic [31:0] word_count;
   logic [31:0] error_count;
   logic        error_flag;
`ifdef PIPE_IN_CHECK_ERRLOG_EN
   logic [31:0] first_err_index;
   logic [31:0] first_err_expected;
   logic [31:0] first_err_actual;
`endif

   typedef struct {
      int          due;
      int          field;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   pipe_in_check dut (
      .clk                (clk),
      .reset              (reset),
      .pipe_in_write      (pipe_in_write),
      .pipe_in_data       (pipe_in_data),
      .pipe_in_ready      (pipe_in_ready),
      .throttle_set       (throttle_set),
      .throttle_val       (throttle_val),
      .fixed_pattern      (fixed_pattern),
      .pattern            (pattern),
      .word_count         (word_count),
      .error_count        (error_count),
      .error_flag         (error_flag)
`ifdef PIPE_IN_CHECK_ERRLOG_EN
      ,
      .first_err_index    (first_err_index),
      .first_err_expected (first_err_expected),
      .first_err_actual   (first_err_actual)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] observe(input int field);
      case (field)
         F_WC:    return word_count;
         F_EC:    return error_count;
         F_EF:    return {31'd0, error_flag};
         F_RDY:   return {31'd0, pipe_in_ready};
`ifdef PIPE_IN_CHECK_ERRLOG_EN
         F_IDX:   return first_err_index;
         F_EXP:   return first_err_expected;
         F_ACT:   return first_err_actual;
`endif
         default: return 32'hXXXX_XXXX;
      endcase
   endfunction

   // Monitor: compare every expectation whose cycle has arrived.
   always @(negedge clk) begin
      int          i;
      logic [31:0] act;
      i = 0;
      while (i < q.size()) begin
         if (q[i].due <= cyc) begin
            act    = observe(q[i].field);
            checks = checks + 1;
            if (act !== q[i].val) begin
               errors = errors + 1;
               $display("FAIL %s got %h want %h (cycle %0d)", q[i].name, act, q[i].val, cyc);
            end
            q.delete(i);
         end else begin
            i = i + 1;
         end
      end
   end

   task automatic expect_at(input int off, input int field, input logic [31:0] val, input string name);
      exp_t e;
      e.due   = cyc + off;
      e.field = field;
      e.val   = val;
      e.name  = name;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [2:0] p, input logic [31:0] tval, input string tag);
      reset         = 1'b1;
      pipe_in_write = 1'b0;
      pattern       = p;
      throttle_set  = 1'b1;
      throttle_val  = tval;
      tick();
      tick();
      expect_at(0, F_WC,  32'd0, {tag, "_rst_wc"});
      expect_at(0, F_EC,  32'd0, {tag, "_rst_ec"});
      expect_at(0, F_EF,  32'd0, {tag, "_rst_ef"});
      expect_at(0, F_RDY, 32'd0, {tag, "_rst_rdy"});
      reset        = 1'b0;
      throttle_set = 1'b0;
      expect_at(1, F_RDY, 32'd1, {tag, "_rdy_after_rst"});
   endtask

   task automatic wr(input logic [31:0] d);
      pipe_in_write = 1'b1;
      pipe_in_data  = d;
   endtask

   initial begin
      reset         = 1'b1;
      pipe_in_write = 1'b0;
      pipe_in_data  = 32'd0;
      throttle_set  = 1'b1;
      throttle_val  = 32'd0;
      fixed_pattern = 32'd0;
      pattern       = 3'd0;

      // COUNT: three correct words
      do_reset(3'd1, 32'h0, "cnt");
      wr(32'h1); tick();
      wr(32'h2); tick();
      wr(32'h3);
      expect_at(1, F_WC, 32'd3, "cnt_wc");
      expect_at(1, F_EC, 32'd0, "cnt_ec");
      expect_at(1, F_EF, 32'd0, "cnt_ef");
      tick();
      pipe_in_write = 1'b0;
      tick();

      // LFSR: two good words, then a bad one, then another bad one
      do_reset(3'd2, 32'h0, "lfsr");
      wr(32'h0D0C_0B0A); tick();
      wr(32'h1A18_1615);
      expect_at(1, F_EC, 32'd0, "lfsr_ec_good");
      tick();
      wr(32'hDEAD_BEEF);
      expect_at(0, F_EC, 32'd0, "lfsr_ec_before_edge");
      expect_at(1, F_EC, 32'd1, "lfsr_ec_err");
      expect_at(1, F_EF, 32'd1, "lfsr_ef_err");
      expect_at(1, F_WC, 32'd3, "lfsr_wc");
`ifdef PIPE_IN_CHECK_ERRLOG_EN
      expect_at(1, F_IDX, 32'd2,          "log_idx");
      expect_at(1, F_EXP, 32'h3430_2C2B,  "log_exp");
      expect_at(1, F_ACT, 32'hDEAD_BEEF,  "log_act");
`endif
      tick();
      wr(32'h0);
      expect_at(1, F_EC, 32'd2, "lfsr_ec_second");
      expect_at(1, F_EF, 32'd1, "lfsr_ef_sticky");
`ifdef PIPE_IN_CHECK_ERRLOG_EN
      expect_at(1, F_IDX, 32'd2,         "log_idx_hold");
      expect_at(1, F_ACT, 32'hDEAD_BEEF, "log_act_hold");
`endif
      tick();
      pipe_in_write = 1'b0;
      tick();

      // FIXED: four matches, one mismatch
      fixed_pattern = 32'hA5A5_A5A5;
      do_reset(3'd0, 32'h0, "fix");
      for (int i = 0; i < 4; i++) begin
         wr(32'hA5A5_A5A5); tick();
      end
      wr(32'h5A5A_5A5A);
      expect_at(1, F_EC, 32'd1, "fix_ec");
      expect_at(1, F_WC, 32'd5, "fix_wc");
      expect_at(1, F_EF, 32'd1, "fix_ef");
      tick();
      pipe_in_write = 1'b0;
      tick();

      // Virtual FIFO: all-ones throttle keeps level at 0, then fill to the limit
      do_reset(3'd7, 32'hFFFF_FFFF, "fifo");
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_at(0, F_RDY, 32'd1, "fifo_idle_rdy");
      end
      throttle_set = 1'b1;
      throttle_val = 32'h0;
      tick();
      throttle_set = 1'b0;
      for (int i = 0; i < 64512; i++) begin
         wr(i);
         if (i == 1000)  expect_at(1, F_RDY, 32'd1, "fifo_rdy_mid");
         if (i == 64511) expect_at(1, F_RDY, 32'd1, "fifo_rdy_last_write");
         tick();
      end
      pipe_in_write = 1'b0;
      expect_at(1, F_RDY, 32'd0, "fifo_rdy_full");
      tick();
      wr(32'h1234);
      expect_at(1, F_WC,  32'd64513, "fifo_wc_notready");
      expect_at(1, F_EC,  32'd0,     "fifo_ec_reserved");
      expect_at(1, F_RDY, 32'd0,     "fifo_rdy_still_full");
      tick();
      pipe_in_write = 1'b0;
      tick();

      // WALK1: 33 correct words, then a reserved-mode wrong word
      do_reset(3'd3, 32'h0, "walk");
      for (int i = 0; i < 33; i++) begin
         wr(32'h1 << (i % 32));
         tick();
      end
      pipe_in_write = 1'b0;
      expect_at(0, F_EC, 32'd0,  "walk_ec");
      expect_at(0, F_WC, 32'd33, "walk_wc");
      pattern = 3'd5;
      wr(32'h1234_5678);
      expect_at(1, F_EC, 32'd0,  "rsv_ec_hold");
      expect_at(1, F_EF, 32'd0,  "rsv_ef_hold");
      expect_at(1, F_WC, 32'd34, "rsv_wc");
      tick();
      pattern = 3'd3;
      wr(32'h0);
      expect_at(1, F_EC, 32'd1, "walk_ec_err");
      tick();
      pipe_in_write = 1'b0;
      tick();

      // Reset wins over a simultaneous wrong write
      reset = 1'b1;
      wr(32'h0000_0BAD);
      expect_at(1, F_WC, 32'd0, "rstw_wc");
      expect_at(1, F_EC, 32'd0, "rstw_ec");
      expect_at(1, F_EF, 32'd0, "rstw_ef");
      tick();
      pipe_in_write = 1'b0;
      tick();
      reset = 1'b0;
      expect_at(1, F_WC, 32'd0, "rstw_wc_after");
      expect_at(1, F_EF, 32'd0, "rstw_ef_after");
      tick();

      repeat (3) tick();
      if (q.size() != 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL drain pending %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
